// File: rtl/sim_monitor_pkg.sv
// Shared types and helpers for the simulation commit monitor.
package sim_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_e;

    // Saturating add of two unsigned values, clamped to 2^width-1 (width <= 128).
    function automatic logic [127:0] sat_add(input logic [127:0] a,
                                             input logic [127:0] b,
                                             input int           width);
        logic [128:0] w_sum;
        logic [128:0] w_lim;
        w_sum = {1'b0, a} + {1'b0, b};
        w_lim = (129'd1 << width) - 129'd1;
        return (w_sum > w_lim) ? w_lim[127:0] : w_sum[127:0];
    endfunction

endpackage

// File: rtl/sim_commit_counter.sv
// Saturating CNT_W-bit accumulator with enable and freeze, used per core and for the total.
module sim_commit_counter
    import sim_monitor_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int INC_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_freeze,
    input  logic [INC_W-1:0] i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt;

    always_comb begin
        w_nxt = r_cnt;
        if (i_en && !i_freeze)
            w_nxt = CNT_W'(sat_add(128'(r_cnt), 128'(i_inc), CNT_W));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_nxt;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sim_commit_monitor.sv
// Condenses per-core commit reports into a registered commit strobe, retired-instruction
// counters and a sticky instruction-limit flag.
module sim_commit_monitor
    import sim_monitor_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int COMMIT_W  = 4,
    parameter int CNT_W     = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          io_commit_valid,
    input  logic [NUM_CORES*COMMIT_W-1:0] io_commit_cnt,
    input  logic [CNT_W-1:0]              io_max_instr,
    output logic                          io_valid,
    output logic [NUM_CORES-1:0]          io_started,
    output logic [NUM_CORES*CNT_W-1:0]    io_core_instr,
    output logic [CNT_W-1:0]              io_total_instr,
    output logic                          io_limit_hit
);

    localparam int SUM_W = CNT_W + $clog2(NUM_CORES);

    mon_state_e             r_state;
    mon_state_e             w_state_nxt;
    logic                   r_valid;
    logic [NUM_CORES-1:0]   r_started;
    logic [NUM_CORES-1:0]   w_eff;
    logic                   w_any;
    logic                   w_frozen;
    logic                   w_limit;
    logic [SUM_W-1:0]       w_sum;
    logic [CNT_W-1:0]       w_total_nxt;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        // A valid carrying a zero count is not a commit.
        assign w_eff[g] = io_commit_valid[g] && (io_commit_cnt[g*COMMIT_W +: COMMIT_W] != '0);

        sim_commit_counter #(.CNT_W(CNT_W), .INC_W(COMMIT_W)) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .i_en     (w_eff[g]),
            .i_freeze (w_frozen),
            .i_inc    (io_commit_cnt[g*COMMIT_W +: COMMIT_W]),
            .o_cnt    (io_core_instr[g*CNT_W +: CNT_W])
        );
    end

    assign w_any    = |w_eff;
    assign w_frozen = (r_state == DONE);

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (w_eff[i]) w_sum = w_sum + SUM_W'(io_commit_cnt[i*COMMIT_W +: COMMIT_W]);
    end

    sim_commit_counter #(.CNT_W(CNT_W), .INC_W(SUM_W)) u_total (
        .clock    (clock),
        .reset    (reset),
        .i_en     (w_any),
        .i_freeze (w_frozen),
        .i_inc    (w_sum),
        .o_cnt    (io_total_instr)
    );

    // Value the total register takes at the next edge, used to raise the flag in step with it.
    always_comb begin
        w_total_nxt = io_total_instr;
        if (w_any)
            w_total_nxt = CNT_W'(sat_add(128'(io_total_instr), 128'(w_sum), CNT_W));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_limit     = (io_max_instr != '0) && (w_total_nxt >= io_max_instr);
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = w_limit ? DONE : RUN;
            RUN:     if (w_limit) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_started <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_any;
            r_started <= r_started | (w_eff & {NUM_CORES{!w_frozen}});
        end
    end

    assign io_valid     = r_valid;
    assign io_started   = r_started;
    assign io_limit_hit = (r_state == DONE);

endmodule
